// File: rtl/escritor_salida.sv
// escritor_salida: serialises LANES-pixel batches into a byte-wide frame memory in raster order
// Ports: iniciar_cuadro/ancho_salida/alto_salida/base_direccion start a frame; modo_paso/paso pick
// free-running or single-step writes; lote_valido/pixel_entrada/listo_lote bring batches in;
// mem_we/mem_addr/mem_dato drive the memory; columna/fila/ocupado/cuadro_listo/desborde report status.
module escritor_salida #(
  parameter int LANES  = 4,
  parameter int DIM_W  = 10,
  parameter int ADDR_W = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 iniciar_cuadro,
  input  logic [DIM_W-1:0]     ancho_salida,
  input  logic [DIM_W-1:0]     alto_salida,
  input  logic [ADDR_W-1:0]    base_direccion,
  input  logic                 modo_paso,
  input  logic                 paso,
  input  logic                 lote_valido,
  input  logic [LANES*8-1:0]   pixel_entrada,
  output logic                 listo_lote,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [7:0]           mem_dato,
  output logic [DIM_W-1:0]     columna,
  output logic [DIM_W-1:0]     fila,
  output logic                 ocupado,
  output logic                 cuadro_listo,
  output logic                 desborde
);
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CW = 2 * DIM_W;
  typedef enum logic [1:0] {REPOSO, ESPERA_LOTE, ESCRIBE, FIN} estado_t;
  estado_t r_est, w_sig;
  logic [DIM_W-1:0]  r_ancho, r_col, r_fila;
  logic [CW-1:0]     r_total, r_cnt, w_total;
  logic [ADDR_W-1:0] r_dir, r_addr;
  logic [LW-1:0]     r_carril, w_carril;
  logic [7:0]        r_buf [LANES];
  logic [7:0]        r_dato, w_dato;
  logic              r_agotado, r_we, r_desborde;
  logic              w_inicio, w_acepta, w_emite, w_ultimo, w_fin_fila;

  assign w_total  = CW'(ancho_salida) * CW'(alto_salida);
  assign mem_we   = r_we;
  assign mem_addr = r_addr;
  assign mem_dato = r_dato;
  assign columna  = r_col;
  assign fila     = r_fila;
  assign desborde = r_desborde;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_est <= REPOSO;
    else     r_est <= w_sig;
  end

  // ESCRIBE is left on the cycle that presents the last write, so the
  // following state is visible only once that write has been committed.
  always_comb begin
    w_sig = r_est;
    case (r_est)
      REPOSO:      if (iniciar_cuadro) w_sig = (w_total == '0) ? FIN : ESPERA_LOTE;
      ESPERA_LOTE: if (lote_valido) w_sig = ESCRIBE;
      ESCRIBE:     if (r_agotado) w_sig = (r_cnt == r_total) ? FIN : ESPERA_LOTE;
      default:     w_sig = REPOSO;
    endcase
  end

  // In free-running mode lane 0 is issued on the accepting edge itself, so the
  // memory strobe is registered yet lines up with the ESCRIBE cycles.
  always_comb begin
    listo_lote   = r_est == ESPERA_LOTE;
    ocupado      = r_est != REPOSO;
    cuadro_listo = r_est == FIN;
    w_inicio     = r_est == REPOSO && iniciar_cuadro;
    w_acepta     = r_est == ESPERA_LOTE && lote_valido;
    w_emite      = (w_acepta && !modo_paso) || (r_est == ESCRIBE && !r_agotado && (!modo_paso || paso));
    w_carril     = w_acepta ? '0 : r_carril;
    w_dato       = w_acepta ? pixel_entrada[7:0] : r_buf[r_carril];
    w_ultimo     = r_cnt + CW'(1) == r_total || w_carril == LW'(LANES - 1);
    w_fin_fila   = r_col == r_ancho - DIM_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ancho    <= '0;
      r_total    <= '0;
      r_cnt      <= '0;
      r_dir      <= '0;
      r_col      <= '0;
      r_fila     <= '0;
      r_carril   <= '0;
      r_agotado  <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_dato     <= '0;
      r_desborde <= 1'b0;
      for (int i = 0; i < LANES; i++) r_buf[i] <= '0;
    end else begin
      r_we <= w_emite;
      if (w_inicio) begin
        r_ancho    <= ancho_salida;
        r_total    <= w_total;
        r_cnt      <= '0;
        r_dir      <= base_direccion;
        r_col      <= '0;
        r_fila     <= '0;
        r_desborde <= 1'b0;
      end
      if (lote_valido && !listo_lote) r_desborde <= 1'b1;
      if (w_acepta) begin
        for (int i = 0; i < LANES; i++) r_buf[i] <= pixel_entrada[i*8 +: 8];
        r_carril  <= '0;
        r_agotado <= 1'b0;
      end
      if (w_emite) begin
        r_addr    <= r_dir;
        r_dato    <= w_dato;
        r_dir     <= r_dir + ADDR_W'(1);
        r_cnt     <= r_cnt + CW'(1);
        r_carril  <= w_carril + LW'(1);
        r_agotado <= w_ultimo;
        r_col     <= w_fin_fila ? '0 : r_col + DIM_W'(1);
        r_fila    <= w_fin_fila ? r_fila + DIM_W'(1) : r_fila;
      end
    end
  end
endmodule
